// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM encoding, the per-stage stall vectors and the stage bit indices.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL_ID = 2'd1,
    STALL_EX = 2'd2,
    FLUSH    = 2'd3
  } pipe_state_t;

  localparam int NUM_STAGES = 6;
  localparam int STAGE_PC   = 0;
  localparam int STAGE_IF   = 1;
  localparam int STAGE_ID   = 2;
  localparam int STAGE_EX   = 3;
  localparam int STAGE_MEM  = 4;
  localparam int STAGE_WB   = 5;

  // A stall holds the requesting stage and everything upstream of it
  localparam logic [NUM_STAGES-1:0] STALL_NONE = 6'b000000;
  localparam logic [NUM_STAGES-1:0] STALL_ID_V = 6'b000111;
  localparam logic [NUM_STAGES-1:0] STALL_EX_V = 6'b001111;

  localparam int               CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and pipe_ctrl (slave).
// The wdog_err_o signal exists only when PIPE_WDOG_EN is defined.
interface pipe_ctrl_if #(
  parameter int PC_W = 12
);

  logic            stallreq_id;
  logic            stallreq_ex;
  logic            branch_flag_i;
  logic [PC_W-1:0] branch_target_i;
  logic [5:0]      stall_o;
  logic            flush_o;
  logic [PC_W-1:0] new_pc_o;
  logic [7:0]      stall_cnt_o;
`ifdef PIPE_WDOG_EN
  logic            wdog_err_o;

  modport master (
    output stallreq_id, stallreq_ex, branch_flag_i, branch_target_i,
    input  stall_o, flush_o, new_pc_o, stall_cnt_o, wdog_err_o
  );

  modport slave (
    input  stallreq_id, stallreq_ex, branch_flag_i, branch_target_i,
    output stall_o, flush_o, new_pc_o, stall_cnt_o, wdog_err_o
  );
`else
  modport master (
    output stallreq_id, stallreq_ex, branch_flag_i, branch_target_i,
    input  stall_o, flush_o, new_pc_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_id, stallreq_ex, branch_flag_i, branch_target_i,
    output stall_o, flush_o, new_pc_o, stall_cnt_o
  );
`endif

endinterface

// File: rtl/pipe_stall_cnt.sv
// Saturating count of consecutive stall cycles; clr wins over inc.
module pipe_stall_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall vector, branch flush/redirect and stall counter.
// Optional sticky stall watchdog enabled by defining PIPE_WDOG_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W       = 12,
  parameter int WDOG_LIMIT = 64
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  pipe_state_t           state;
  logic                  flush_q;
  logic [PC_W-1:0]       new_pc_q;
  logic                  pend_q;
  logic [PC_W-1:0]       pend_pc;
  logic [NUM_STAGES-1:0] stall_vec;
  logic                  stall_any;
  logic [CNT_W-1:0]      stall_cnt;

  // Requests during FLUSH belong to squashed instructions, so they are dropped
  always_comb begin
    stall_vec = STALL_NONE;
    if (rst_n && (state != FLUSH)) begin
      if (bus.stallreq_ex) begin
        stall_vec = STALL_EX_V;
      end else if (bus.stallreq_id) begin
        stall_vec = STALL_ID_V;
      end
    end
  end

  assign stall_any = |stall_vec;

  // A branch seen under an execute stall is parked until execute releases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
      pend_q   <= 1'b0;
      pend_pc  <= '0;
    end else begin
      flush_q <= 1'b0;
      if (state == FLUSH) begin
        state <= RUN;
      end else if (bus.stallreq_ex) begin
        state <= STALL_EX;
        if (bus.branch_flag_i) begin
          pend_q  <= 1'b1;
          pend_pc <= bus.branch_target_i;
        end
      end else if (bus.branch_flag_i || pend_q) begin
        state    <= FLUSH;
        flush_q  <= 1'b1;
        pend_q   <= 1'b0;
        new_pc_q <= bus.branch_flag_i ? bus.branch_target_i : pend_pc;
      end else if (bus.stallreq_id) begin
        state <= STALL_ID;
      end else begin
        state <= RUN;
      end
    end
  end

  pipe_stall_cnt u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_any),
    .clr   (~stall_any),
    .count (stall_cnt)
  );

  assign bus.stall_o     = stall_vec;
  assign bus.flush_o     = flush_q;
  assign bus.new_pc_o    = new_pc_q;
  assign bus.stall_cnt_o = stall_cnt;

`ifdef PIPE_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_TRIP = CNT_W'(WDOG_LIMIT - 1);

  logic wdog_q;

  // Trips on the same edge that carries the count up to WDOG_LIMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= 1'b0;
    end else if (stall_any && (stall_cnt == WDOG_TRIP)) begin
      wdog_q <= 1'b1;
    end
  end

  assign bus.wdog_err_o = wdog_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expectations, a monitor checks them.
// Watchdog expectations are compared only when PIPE_WDOG_EN is defined.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [5:0] S0 = STALL_NONE;
  localparam logic [5:0] SI = STALL_ID_V;
  localparam logic [5:0] SE = STALL_EX_V;

  typedef struct {
    int          vid;
    logic [5:0]  stall;
    logic        flush;
    logic [11:0] pc;
    logic [7:0]  cnt;
    pipe_state_t st;
    logic        wdog;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   vec_no;
  exp_t exp_q[$];
  event chk_now;

  pipe_ctrl_if #(.PC_W(12)) bus ();

  pipe_ctrl #(
    .PC_W       (12),
    .WDOG_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string what, input int vid, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL vec%0d %s: got 0x%0h expected 0x%0h", vid, what, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("stall_o", e.vid, 32'(bus.stall_o), 32'(e.stall));
    cmp("flush_o", e.vid, 32'(bus.flush_o), 32'(e.flush));
    cmp("new_pc_o", e.vid, 32'(bus.new_pc_o), 32'(e.pc));
    cmp("stall_cnt_o", e.vid, 32'(bus.stall_cnt_o), 32'(e.cnt));
    cmp("state", e.vid, 32'(dut.state), 32'(e.st));
`ifdef PIPE_WDOG_EN
    cmp("wdog_err_o", e.vid, 32'(bus.wdog_err_o), 32'(e.wdog));
`endif
  endtask

  task automatic driveAndExpect(input logic id, input logic ex, input logic br, input logic [11:0] tgt,
                                input logic [5:0] e_stall, input logic e_flush, input logic [11:0] e_pc,
                                input logic [7:0] e_cnt, input pipe_state_t e_st, input logic e_wdog);
    exp_t e;
    bus.stallreq_id     = id;
    bus.stallreq_ex     = ex;
    bus.branch_flag_i   = br;
    bus.branch_target_i = tgt;
    e.vid   = vec_no;
    e.stall = e_stall;
    e.flush = e_flush;
    e.pc    = e_pc;
    e.cnt   = e_cnt;
    e.st    = e_st;
    e.wdog  = e_wdog;
    vec_no++;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic id, input logic ex, input logic br, input logic [11:0] tgt,
                               input logic [5:0] e_stall, input logic e_flush, input logic [11:0] e_pc,
                               input logic [7:0] e_cnt, input pipe_state_t e_st, input logic e_wdog);
    driveAndExpect(id, ex, br, tgt, e_stall, e_flush, e_pc, e_cnt, e_st, e_wdog);
    @(posedge clk);
    #1;
  endtask

  // Outputs are compared mid-cycle, or immediately when an asynchronous event is checked
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #50000;
    errors++;
    $display("[TB] FAIL timeout: got no end of stimulus expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    checks = 0;
    errors = 0;
    vec_no = 0;
    rst_n  = 1'b0;
    bus.stallreq_id     = 1'b0;
    bus.stallreq_ex     = 1'b0;
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = '0;
    repeat (2) @(posedge clk);
    #1;

    applyStimulus(1, 1, 1, 12'h055, S0, 0, 12'h000, 0, RUN, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h000, 0, RUN, 0);

    $display("[TB] load-use and simultaneous requests");
    applyStimulus(1, 0, 0, 12'h000, SI, 0, 12'h000, 0, RUN, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h000, 1, STALL_ID, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h000, 0, RUN, 0);
    applyStimulus(1, 1, 0, 12'h000, SE, 0, 12'h000, 0, RUN, 0);
    applyStimulus(1, 1, 0, 12'h000, SE, 0, 12'h000, 1, STALL_EX, 0);
    applyStimulus(1, 0, 0, 12'h000, SI, 0, 12'h000, 2, STALL_EX, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h000, 3, STALL_ID, 0);

    $display("[TB] branch redirect and back-to-back branches");
    applyStimulus(0, 0, 1, 12'h0A4, S0, 0, 12'h000, 0, RUN, 0);
    applyStimulus(1, 1, 1, 12'h333, S0, 1, 12'h0A4, 0, FLUSH, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h0A4, 0, RUN, 0);
    applyStimulus(0, 0, 1, 12'h011, S0, 0, 12'h0A4, 0, RUN, 0);
    applyStimulus(0, 0, 1, 12'h022, S0, 1, 12'h011, 0, FLUSH, 0);
    applyStimulus(0, 0, 1, 12'h033, S0, 0, 12'h011, 0, RUN, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 1, 12'h033, 0, FLUSH, 0);
    applyStimulus(0, 0, 1, 12'h044, S0, 0, 12'h033, 0, RUN, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 1, 12'h044, 0, FLUSH, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h044, 0, RUN, 0);

    $display("[TB] branch held under execute stall");
    applyStimulus(0, 1, 0, 12'h000, SE, 0, 12'h044, 0, RUN, 0);
    applyStimulus(0, 1, 1, 12'h100, SE, 0, 12'h044, 1, STALL_EX, 0);
    applyStimulus(0, 1, 0, 12'h000, SE, 0, 12'h044, 2, STALL_EX, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h044, 3, STALL_EX, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 1, 12'h100, 0, FLUSH, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h100, 0, RUN, 0);

    $display("[TB] watchdog with limit 4");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 12'h000, SE, 0, 12'h100, 8'(i), (i == 0) ? RUN : STALL_EX, (i >= 4));
    end
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h100, 6, STALL_EX, 1);
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h100, 0, RUN, 1);

    $display("[TB] counter saturation");
    for (int i = 0; i < 260; i++) begin
      applyStimulus(0, 1, 0, 12'h000, SE, 0, 12'h100, (i > 255) ? 8'd255 : 8'(i),
                    (i == 0) ? RUN : STALL_EX, 1);
    end
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h100, 255, STALL_EX, 1);

    $display("[TB] reset during flush");
    applyStimulus(0, 0, 1, 12'h0FF, S0, 0, 12'h100, 0, RUN, 1);
    driveAndExpect(1, 1, 0, 12'h000, S0, 1, 12'h0FF, 0, FLUSH, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    driveAndExpect(1, 1, 0, 12'h000, S0, 0, 12'h000, 0, RUN, 0);
    ->chk_now;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h000, 0, RUN, 0);
    applyStimulus(1, 0, 0, 12'h000, SI, 0, 12'h000, 0, RUN, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h000, 1, STALL_ID, 0);
    applyStimulus(0, 0, 0, 12'h000, S0, 0, 12'h000, 0, RUN, 0);

    @(negedge clk);
    #1;
    cmp("scoreboard_drained", vec_no, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter PC_W, default 12: width of the branch target and redirect PC.
REQ-002 Parameter WDOG_LIMIT, default 64: consecutive-stall count that trips the watchdog; legal range 2..255.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port stallreq_id, input, 1: load-use stall request from decode.
REQ-006 Port stallreq_ex, input, 1: multi-cycle execute stall request.
REQ-007 Port branch_flag_i, input, 1: execute resolved a taken branch or jump.
REQ-008 Port branch_target_i, input, PC_W: redirect address; valid when branch_flag_i=1.
REQ-009 Port stall_o, output, 6: per-stage hold. Bit 0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb.
REQ-010 Port flush_o, output, 1: squash the if/id/ex pipeline registers.
REQ-011 Port new_pc_o, output, PC_W: redirect PC; meaningful only while flush_o=1.
REQ-012 Port stall_cnt_o, output, 8: current count of consecutive stall cycles, saturating.
REQ-013 Port wdog_err_o, output, 1: sticky watchdog flag; present only with PIPE_WDOG_EN.

Function
REQ-014 The FSM SHALL have four states: RUN, STALL_ID, STALL_EX, FLUSH.
REQ-015 stall_o SHALL be combinational from the inputs and the state.
  - stallreq_ex=1 -> 6'b001111.
  - Else stallreq_id=1 -> 6'b000111.
  - Else 6'b000000.
  - Execute has priority over decode.
REQ-016 In FLUSH, stall_o SHALL be 6'b000000 and both stall requests SHALL be ignored, because they come from squashed instructions.
REQ-017 The FSM state SHALL follow the request that drives stall_o.
  - STALL_EX while stallreq_ex=1.
  - STALL_ID while stallreq_id=1 and stallreq_ex=0.
  - Return to RUN on the first cycle with no request.
REQ-018 Branch redirect SHALL work as follows.
  - branch_flag_i=1 with stallreq_ex=0 and state not FLUSH latches branch_target_i.
  - The next cycle enters FLUSH.
  - In FLUSH, flush_o=1 and new_pc_o equals the latched target, for exactly one cycle.
  - The FSM then returns to RUN.
REQ-019 A branch arriving while stallreq_ex=1 SHALL be held pending with its target latched; FLUSH SHALL follow on the cycle after stallreq_ex falls.
REQ-020 A branch_flag_i asserted during FLUSH SHALL be ignored.
REQ-021 Back-to-back branches in consecutive non-FLUSH cycles SHALL each produce their own one-cycle FLUSH.
REQ-022 The stall counter SHALL behave as follows.
  - Increments each cycle stall_o is nonzero.
  - Clears to 0 on any cycle stall_o is zero.
  - Saturates at 255.
  - stall_cnt_o shows the registered value.
REQ-023 flush_o and new_pc_o SHALL be registered, with exactly one cycle of latency from the branch_flag_i sample.

Reset
REQ-024 Asserting rst_n low SHALL immediately force the following, from any state including mid-stall and mid-flush:
  - state=RUN.
  - flush_o=0.
  - new_pc_o=0.
  - stall_cnt_o=0.
  - wdog_err_o=0.
  - any pending branch cleared.
REQ-025 While in reset, stall_o SHALL be 6'b000000 regardless of the inputs.
REQ-026 The first rising clk edge after rst_n rises SHALL sample the inputs normally.

Configuration
REQ-027 With macro PIPE_WDOG_EN defined:
  - wdog_err_o SHALL set on the edge where stall_cnt_o reaches WDOG_LIMIT.
  - It SHALL stay set until reset.
  - It SHALL have no effect on stall_o or flush_o.
REQ-028 With PIPE_WDOG_EN undefined, the wdog_err_o port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package pipe_ctrl_pkg SHALL hold:
  - the state encoding;
  - the stall-vector constants STALL_NONE, STALL_ID_V and STALL_EX_V;
  - the stage bit indices.
REQ-030 The saturating counter SHALL be a sub-module named pipe_stall_cnt, with clk, rst_n, inc and clr inputs and an 8-bit count output.

Verification
REQ-031 The bench SHALL cover the following directed scenarios.
  - Load-use: stallreq_id=1 for 1 cycle -> stall_o=000111 that cycle, stall_cnt_o=1 next cycle, then 0.
  - Simultaneous requests: stallreq_id=1 and stallreq_ex=1 -> stall_o=001111; state STALL_EX.
  - Branch: branch_flag_i=1, target 12'h0A4 -> next cycle flush_o=1, new_pc_o=0A4 for one cycle only; the following cycle flush_o=0.
  - Branch under execute stall: stallreq_ex=1 for 3 cycles with branch_flag_i pulsed, target 12'h100, in cycle 1 -> flush_o=1 with new_pc_o=100 on the cycle after stallreq_ex falls.
  - Watchdog (PIPE_WDOG_EN, WDOG_LIMIT=4): stallreq_ex held 6 cycles -> wdog_err_o rises when stall_cnt_o=4 and stays high after the stall ends.
  - Reset mid-flush: rst_n low during FLUSH -> flush_o=0, new_pc_o=0 and stall_o=0 immediately, without waiting for a clock.
